// File: rtl/smg_pkg.sv
// Shared constants for the seven-segment scan controller: segment bit
// positions, the hex glyph table and the prescaler divisor helper.
package smg_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Active-high g..a glyphs, indexed by nibble value
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned scan_hz);
    return clk_hz / scan_hz;
  endfunction

endpackage

// File: rtl/smg_scan_ctrl_if.sv
// Display bus between a data source and the scan controller: packed digit
// nibbles and decimal points in, multiplexed digit/segment drive out.
interface smg_scan_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   smg_sig;
  logic [7:0]          smg_data;
  logic                rdsig_nextdata;

  modport master (
    output data, dp,
    input  smg_sig, smg_data, rdsig_nextdata
  );

  modport slave (
    input  data, dp,
    output smg_sig, smg_data, rdsig_nextdata
  );
endinterface

// File: rtl/smg_hex_decode.sv
// Combinational nibble-to-glyph decoder, active-high segments g..a.
module smg_hex_decode
  import smg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TABLE[nib_i];
endmodule

// File: rtl/smg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-slot anti-ghost blanking,
// frame-synchronous shadow registers and optional leading-zero suppression.
module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned SCAN_HZ     = 1000,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned BLANK_CYC   = 500,
  parameter bit          ACT_LOW     = 1'b1,
  parameter bit          LZ_SUPPRESS = 1'b1
) (
  input logic            clk_50MHz,
  input logic            rst,
  smg_scan_ctrl_if.slave bus
);
  localparam int unsigned DIV = calc_div(CLK_HZ, SCAN_HZ);
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned IW  = $clog2(DIGITS);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                rdsig_q, rdsig_d;
  logic [DIGITS-1:0]   sig_q, sig_d;
  logic [7:0]          seg_q, seg_d;
  logic                tick, frame;
  logic [3:0]          nib;
  logic [6:0]          seg7;
  logic [DIGITS-1:0]   lz_blank;
  logic                all_zero;
  logic [DIGITS-1:0]   sig_act;
  logic [7:0]          seg_act;

  always_comb begin
    tick      = (cnt_q == CW'(DIV - 1));
    frame     = tick && (idx_q == IW'(DIGITS - 1));
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    sh_data_d = sh_data_q;
    sh_dp_d   = sh_dp_q;
    if (tick) idx_d = frame ? '0 : idx_q + 1'b1;
    if (frame) begin
      sh_data_d = bus.data;
      sh_dp_d   = bus.dp;
    end
    rdsig_d = (cnt_d == CW'(DIV - 1)) && (idx_d == IW'(DIGITS - 1));
  end

  // Outputs are registered from next-state values so each one lines up with
  // the cnt/idx/shadow state that is current in the cycle it is visible.
  assign nib = sh_data_d[{idx_d, 2'b00} +: 4];

  smg_hex_decode u_dec (
    .nib_i (nib),
    .seg_o (seg7)
  );

  always_comb begin
    lz_blank = '0;
    all_zero = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      all_zero    = all_zero && (sh_data_d[4*i +: 4] == 4'h0) && !sh_dp_d[i];
      lz_blank[i] = all_zero;
    end

    sig_act        = '0;
    sig_act[idx_d] = 1'b1;
    seg_act        = {1'b0, seg7};
    seg_act[SEG_DP] = sh_dp_d[idx_d];
    if (LZ_SUPPRESS && lz_blank[idx_d]) seg_act = '0;

    sig_d = sig_act;
    seg_d = seg_act;
    if (cnt_d < CW'(BLANK_CYC)) begin
      sig_d = '0;
      seg_d = '0;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_data_q <= '0;
      sh_dp_q   <= '0;
      rdsig_q   <= 1'b0;
      sig_q     <= {DIGITS{ACT_LOW}};
      seg_q     <= {8{ACT_LOW}};
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_data_q <= sh_data_d;
      sh_dp_q   <= sh_dp_d;
      rdsig_q   <= rdsig_d;
      sig_q     <= sig_d ^ {DIGITS{ACT_LOW}};
      seg_q     <= seg_d ^ {8{ACT_LOW}};
    end
  end

  assign bus.smg_sig        = sig_q;
  assign bus.smg_data       = seg_q;
  assign bus.rdsig_nextdata = rdsig_q;

endmodule

// File: doc/smg_scan_ctrl.md
SMG_SCAN_CTRL -- requirements
Module: smg_scan_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: input clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000: per-digit scan rate; DIV = CLK_HZ/SCAN_HZ, DIV SHALL be >= 4.
REQ-003 Parameter DIGITS, default 4, range 2..8: number of multiplexed digits.
REQ-004 Parameter BLANK_CYC, default 500: anti-ghost blank cycles per digit slot; 0 <= BLANK_CYC < DIV.
REQ-005 Parameter ACT_LOW, default 1: when 1, smg_sig and smg_data are active-low.
REQ-006 Parameter LZ_SUPPRESS, default 1: enable leading-zero blanking.
REQ-007 clk_50MHz  in  1  sole clock, all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 data  in  4*DIGITS  packed hex nibbles; nibble i = data[4i+3:4i], digit 0 rightmost.
REQ-010 dp  in  DIGITS  decimal-point request per digit.
REQ-011 smg_sig  out  DIGITS  digit select, one-hot when active.
REQ-012 smg_data  out  8  segments: bit7 = dp, bits 6..0 = g,f,e,d,c,b,a.
REQ-013 rdsig_nextdata  out  1  one-cycle pulse marking a shadow-register load (frame boundary).

Function
REQ-014 Prescaler cnt counts 0..DIV-1 and wraps to 0. tick is asserted in the cycle where cnt == DIV-1.
REQ-015 On tick, digit index idx advances by 1 and wraps from DIGITS-1 to 0.
REQ-016 On a tick where idx == DIGITS-1, shadow registers take data and dp, and rdsig_nextdata is 1 for that single cycle.
REQ-017 Displayed content comes only from the shadow registers. Changes to data or dp mid-frame have no visible effect until the next frame boundary.
REQ-018 While cnt < BLANK_CYC, smg_sig is all-inactive and smg_data is all-inactive.
REQ-019 Otherwise, smg_sig drives only bit idx active, and smg_data shows the decode of shadow nibble idx plus dp bit idx.
REQ-020 All outputs are registered. Each output reflects the cnt/idx state that is current in the same cycle, with no combinational path from data or dp.
REQ-021 Hex decode uses the standard table, active-high g..a: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71.
REQ-022 With LZ_SUPPRESS=1, digit i (i>0) is blanked if shadow nibbles DIGITS-1 down to i are all zero and no shadow dp bit in DIGITS-1..i is set. A blanked digit drives segments off while its select is still driven. Digit 0 is never suppressed.
REQ-023 When ACT_LOW=1, smg_sig and smg_data are the bitwise inverse of the active-high values.
REQ-024 rdsig_nextdata pulses exactly once every DIGITS*DIV cycles in steady state.

Reset
REQ-025 While rst=1 at a clock edge: cnt=0, idx=0, shadow data=0, shadow dp=0, rdsig_nextdata=0, smg_sig all-inactive, smg_data all-inactive.
REQ-026 Reset asserted mid-scan takes effect on the next edge. After release, scanning restarts at digit 0 with cnt=0.
REQ-027 The first shadow load after reset occurs at the first frame boundary.

Structure
REQ-028 Package smg_pkg holds the hex-to-segment constant table, the segment bit-position constants, and a function computing DIV.
REQ-029 Combinational sub-module smg_hex_decode (4-bit nibble in, 7 active-high segments out) is instantiated once, fed by the shadow nibble muxed by idx.

Verification
Bench parameters: CLK_HZ=1000, SCAN_HZ=100 (DIV=10), DIGITS=4, BLANK_CYC=2, ACT_LOW=1.
REQ-030 Hold rst for 3 cycles -> smg_sig=4'hF, smg_data=8'hFF, rdsig_nextdata=0. First rdsig_nextdata pulse occurs 40 cycles after release.
REQ-031 data=16'h12AF, dp=0, LZ off -> digit0 slot shows smg_data=8'h8E and smg_sig=4'hE; digit3 shows 8'hF9 and smg_sig=4'h7.
REQ-032 data=16'h0030, LZ on -> digits 3 and 2 show 8'hFF with their selects active; digit1 shows 8'hB0; digit0 shows 8'hC0. Setting dp=4'b0100 -> digit2 shows 8'h40.
REQ-033 Each slot -> 2 cycles with smg_sig=4'hF, then 8 cycles with one-hot-low select. Across a sustained run, rdsig_nextdata is a single-cycle pulse exactly every 40 cycles.
REQ-034 Change data from 16'h1111 to 16'h2222 while idx=1 -> digits 2 and 3 still show "1" (8'hF9) until the wrap tick; "2" (8'hA4) appears from the next frame.
REQ-035 Assert rst for 1 cycle while idx=2, cnt=5 -> outputs take reset values on the next edge. Scan resumes at digit0 with blank for 2 cycles, and shadow shows 0 (8'hC0) until the next load.
